axi_swr_protect: RTL and testbench
==================================

AXI_SWR_PROTECT -- requirements
Module: axi_swr_protect

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 16, AXI-Lite address width.
REQ-003 SHALL have port aclk  in  1  clock; reset aresetn, synchronous, active-low; clock aclk.
REQ-004 SHALL have port aresetn  in  1  synchronous active-low reset.
REQ-005 SHALL have port smp_valid  in  1  one-cycle strobe, one ADC conversion complete.
REQ-006 SHALL have port smp_chan  in  3  ADC channel of sample (0 fwd, 1 rev, 5 supply; others ignored).
REQ-007 SHALL have port smp_data  in  12  conversion result.
REQ-008 SHALL have port tx_inhibit  out  1  high while any trip latched.
REQ-009 SHALL have AXI4-Lite slave ports s_axi_aw*/w*/b*/ar*/r* (address/data widths per parameters; bresp/rresp 2 bits, always 0).

Function
REQ-010 SHALL decode registers on addr[4:2]: 0 CTRL (bit0 enable, bit1 clear-trips W1, reads 0), 1 RHO [7:0], 2 FWD_MIN [11:0], 3 SUPPLY_MAX [11:0], 4 TRIP_CNT [3:0], 5 STATUS RO (bit0 swr_trip, bit1 ov_trip, bit2 tx_inhibit, [27:16] last fwd); others read 0, writes ignored.
REQ-011 SHALL accept a write only when awvalid and wvalid both high with bvalid low: awready=wready=1 for that single cycle, registers update that edge, bvalid next cycle, held until bready.
REQ-012 SHALL accept a read when arvalid and arready: arready drops, rvalid+rdata one cycle later, held until rready; arready re-asserts the cycle after the rvalid&rready transfer.
REQ-013 SHALL capture smp_data into fwd_hold on smp_valid with chan 0, regardless of enable.
REQ-014 SHALL, on smp_valid chan 1 with enable=1, register stage 1: a=rev*256, b=fwd_hold*RHO (both 20-bit unsigned, no truncation).
REQ-015 SHALL in stage 2 call the evaluation failing when a > b and fwd_hold >= FWD_MIN; passing otherwise.
REQ-016 SHALL keep a 4-bit consecutive-fail counter: +1 on fail (saturating at 15), cleared on pass.
REQ-017 SHALL set swr_trip when the counter's new value >= max(TRIP_CNT,1); swr_trip visible the cycle after stage 2, i.e. 3 edges after the rev smp_valid edge.
REQ-018 SHALL, on smp_valid chan 5 with enable=1, apply the same counter/threshold scheme to supply > SUPPLY_MAX using a separate counter, setting ov_trip with equal 3-edge latency.
REQ-019 SHALL latch swr_trip/ov_trip until clear-trips write; clear also zeroes both counters.
REQ-020 SHALL give set priority: trip set and clear-trips in the same cycle leaves the trip set.
REQ-021 SHALL, when enable=0, perform no evaluation, hold counters at 0, and retain latched trips.
REQ-022 SHALL drive tx_inhibit = swr_trip | ov_trip, registered, one edge after the trip sets/clears.
REQ-023 SHALL flush an in-flight stage 1/2 evaluation when enable is written 0 in the same cycle.

Reset
REQ-024 SHALL on reset set: enable 0, RHO 0x80, FWD_MIN 0x100, SUPPLY_MAX 0xFFF, TRIP_CNT 3, fwd_hold 0, counters 0, trips 0, tx_inhibit 0.
REQ-025 SHALL on reset set arready 1, awready/wready/bvalid/rvalid 0, rdata 0; a transaction in progress is abandoned.

Structure
REQ-026 SHALL place register offsets, channel IDs (FWD=0, REV=1, SUPPLY=5) and reset constants in shared package swr_protect_pkg.
REQ-027 SHALL implement the two-stage compare plus counter as sub-module swr_trip_eval, instanced once for SWR, once for supply.

Verification
REQ-028 Reset, read offsets 0..5 -> 0x0, 0x80, 0x100, 0xFFF, 0x3, 0x0; tx_inhibit 0.
REQ-029 Enable, RHO 0x80, fwd 0x400, then three rev 0x300 -> swr_trip and tx_inhibit high after third rev (+3 edges), not after second.
REQ-030 fwd 0x0C0 (< FWD_MIN), rev 0xFFF x5 -> no trip; fail,fail,pass,fail,fail with TRIP_CNT 3 -> no trip.
REQ-031 SUPPLY_MAX 0x900, TRIP_CNT 0, one supply 0x901 -> ov_trip after one sample; supply 0x900 -> none.
REQ-032 Clear-trips written same cycle as a tripping evaluation -> trip remains set; clear after -> STATUS 0, tx_inhibit 0 next edge.
REQ-033 Reset asserted mid-read with rvalid high and rready low -> rvalid 0, arready 1, all registers at reset values next edge.

Source files
------------

// File: rtl/swr_protect_pkg.sv
// Shared constants for the SWR / supply protection block: register map,
// ADC channel IDs, reset values and the trip-threshold helper.
package swr_protect_pkg;

    // Register offsets (word index, addr[4:2])
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_RHO        = 3'd1;
    localparam logic [2:0] REG_FWD_MIN    = 3'd2;
    localparam logic [2:0] REG_SUPPLY_MAX = 3'd3;
    localparam logic [2:0] REG_TRIP_CNT   = 3'd4;
    localparam logic [2:0] REG_STATUS     = 3'd5;

    // ADC channel IDs
    localparam logic [2:0] CHAN_FWD    = 3'd0;
    localparam logic [2:0] CHAN_REV    = 3'd1;
    localparam logic [2:0] CHAN_SUPPLY = 3'd5;

    // Reset values
    localparam logic [7:0]  RST_RHO        = 8'h80;
    localparam logic [11:0] RST_FWD_MIN    = 12'h100;
    localparam logic [11:0] RST_SUPPLY_MAX = 12'hFFF;
    localparam logic [3:0]  RST_TRIP_CNT   = 4'd3;

    // Compare operand width: 12-bit sample * 256 or * 8-bit RHO fits in 20 bits
    localparam int EVAL_W = 20;
    typedef logic [EVAL_W-1:0] eval_t;

    // A programmed count of 0 behaves like 1 so a single failure can trip
    function automatic logic [3:0] trip_threshold(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 4'd1 : cnt;
    endfunction

endpackage

// File: rtl/axi_swr_protect_if.sv
// AXI4-Lite bus bundle for the protection block's register port.
interface axi_swr_protect_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/swr_trip_eval.sv
// Two-stage "a > b" evaluation with a consecutive-fail counter and a latched
// trip. Stage 1 captures operands on the sample edge, stage 2 registers the
// fail decision, and the counter/trip update on the following edge.
module swr_trip_eval
    import swr_protect_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       i_start,
    input  eval_t      i_a,
    input  eval_t      i_b,
    input  logic       i_gate,
    input  logic       i_enable,
    input  logic       i_flush,
    input  logic       i_clear,
    input  logic [3:0] i_trip_cnt,
    output logic       o_trip
);
    localparam int STAGES = 2;

    logic [STAGES:1] r_vld_pipe;
    eval_t           r_a;
    eval_t           r_b;
    logic            r_gate;
    logic            r_fail;
    logic [3:0]      r_cnt;
    logic            r_trip;

    logic            w_run;
    logic            w_vld_in;
    logic            w_eval;
    logic [3:0]      w_cnt_nxt;
    logic            w_trip_set;

    // A disable write (flush) or enable=0 kills anything in flight
    assign w_run    = i_enable & ~i_flush;
    assign w_vld_in = i_start & w_run;
    assign w_eval   = r_vld_pipe[STAGES] & w_run;

    // Fail increments (saturating at 15), pass clears
    assign w_cnt_nxt  = !r_fail ? 4'd0 : ((r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1);
    assign w_trip_set = w_eval & r_fail & (w_cnt_nxt >= trip_threshold(i_trip_cnt));

    // Valid shift register tracking the evaluation through both stages
    always_ff @(posedge aclk) begin
        if (!aresetn) r_vld_pipe <= '0;
        else          r_vld_pipe <= w_run ? {r_vld_pipe[STAGES-1:1], w_vld_in} : '0;
    end

    // Stage 1 operand capture, stage 2 fail decision
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_gate <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            if (w_vld_in) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_gate <= i_gate;
            end
            if (r_vld_pipe[1]) r_fail <= r_gate && (r_a > r_b);
        end
    end

    // Consecutive-fail counter; an evaluation landing with a clear still counts
    always_ff @(posedge aclk) begin
        if (!aresetn)      r_cnt <= 4'd0;
        else if (!i_enable) r_cnt <= 4'd0;
        else if (w_eval)   r_cnt <= w_cnt_nxt;
        else if (i_clear)  r_cnt <= 4'd0;
    end

    // Latched trip; a set in the same cycle as a clear wins
    always_ff @(posedge aclk) begin
        if (!aresetn)        r_trip <= 1'b0;
        else if (w_trip_set) r_trip <= 1'b1;
        else if (i_clear)    r_trip <= 1'b0;
    end

    assign o_trip = r_trip;

endmodule

// File: rtl/axi_swr_protect.sv
// Transmitter protection: trips on sustained high reflected power (SWR) or
// supply over-voltage from ADC samples, with an AXI4-Lite register port.
module axi_swr_protect
    import swr_protect_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,  // must be >= 28 for the STATUS layout
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        smp_valid,
    input  logic [2:0]  smp_chan,
    input  logic [11:0] smp_data,
    output logic        tx_inhibit,
    axi_swr_protect_if.slave s_axi
);
    logic                      r_enable;
    logic [7:0]                r_rho;
    logic [11:0]               r_fwd_min;
    logic [11:0]               r_supply_max;
    logic [3:0]                r_trip_cnt;
    logic [11:0]               r_fwd_hold;
    logic                      r_tx_inhibit;
    logic                      r_bvalid;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [2:0]                w_waddr;
    logic [2:0]                w_raddr;
    logic                      w_ctrl_wr;
    logic                      w_clear;
    logic                      w_flush;
    logic [AXI_DATA_WIDTH-1:0] w_rmux;
    logic                      w_swr_start;
    logic                      w_sup_start;
    eval_t                     w_swr_a;
    eval_t                     w_swr_b;
    logic                      w_swr_gate;
    eval_t                     w_sup_a;
    eval_t                     w_sup_b;
    logic                      w_swr_trip;
    logic                      w_ov_trip;
    logic                      w_unused;

    // Write accepted in the single cycle both channels are valid and no response pending
    assign w_wr_en   = aresetn & s_axi.awvalid & s_axi.wvalid & ~r_bvalid;
    assign w_rd_en   = s_axi.arvalid & r_arready;
    assign w_waddr   = s_axi.awaddr[4:2];
    assign w_raddr   = s_axi.araddr[4:2];
    assign w_ctrl_wr = w_wr_en && (w_waddr == REG_CTRL);
    assign w_clear   = w_ctrl_wr & s_axi.wdata[1];
    assign w_flush   = w_ctrl_wr & ~s_axi.wdata[0];

    assign s_axi.awready = w_wr_en;
    assign s_axi.wready  = w_wr_en;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;

    // Address bits outside addr[4:2], upper data bits and strobes are don't-care
    assign w_unused = &{1'b0, s_axi.awaddr[AXI_ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                        s_axi.araddr[AXI_ADDR_WIDTH-1:5], s_axi.araddr[1:0],
                        s_axi.wdata[AXI_DATA_WIDTH-1:12], s_axi.wstrb};

    // Configuration registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_enable     <= 1'b0;
            r_rho        <= RST_RHO;
            r_fwd_min    <= RST_FWD_MIN;
            r_supply_max <= RST_SUPPLY_MAX;
            r_trip_cnt   <= RST_TRIP_CNT;
        end else if (w_wr_en) begin
            case (w_waddr)
                REG_CTRL:       r_enable     <= s_axi.wdata[0];
                REG_RHO:        r_rho        <= s_axi.wdata[7:0];
                REG_FWD_MIN:    r_fwd_min    <= s_axi.wdata[11:0];
                REG_SUPPLY_MAX: r_supply_max <= s_axi.wdata[11:0];
                REG_TRIP_CNT:   r_trip_cnt   <= s_axi.wdata[3:0];
                default: ;
            endcase
        end
    end

    // Write response: raised after the accept edge, held until bready
    always_ff @(posedge aclk) begin
        if (!aresetn)                     r_bvalid <= 1'b0;
        else if (w_wr_en)                 r_bvalid <= 1'b1;
        else if (r_bvalid && s_axi.bready) r_bvalid <= 1'b0;
    end

    // Read data mux
    always_comb begin
        w_rmux = '0;
        case (w_raddr)
            REG_CTRL:       w_rmux[0]     = r_enable;
            REG_RHO:        w_rmux[7:0]   = r_rho;
            REG_FWD_MIN:    w_rmux[11:0]  = r_fwd_min;
            REG_SUPPLY_MAX: w_rmux[11:0]  = r_supply_max;
            REG_TRIP_CNT:   w_rmux[3:0]   = r_trip_cnt;
            REG_STATUS: begin
                w_rmux[0]     = w_swr_trip;
                w_rmux[1]     = w_ov_trip;
                w_rmux[2]     = r_tx_inhibit;
                w_rmux[27:16] = r_fwd_hold;
            end
            default: ;
        endcase
    end

    // Read channel: one outstanding read, arready returns after the R handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else if (w_rd_en) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rmux;
        end else if (r_rvalid && s_axi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    // Forward power is tracked even while protection is disabled
    always_ff @(posedge aclk) begin
        if (!aresetn)                               r_fwd_hold <= 12'd0;
        else if (smp_valid && smp_chan == CHAN_FWD) r_fwd_hold <= smp_data;
    end

    // SWR: fail when rev*256 > fwd*RHO, only with enough forward power to be meaningful
    assign w_swr_start = smp_valid && (smp_chan == CHAN_REV);
    assign w_swr_a     = {smp_data, 8'h00};
    assign w_swr_b     = EVAL_W'(r_fwd_hold) * EVAL_W'(r_rho);
    assign w_swr_gate  = (r_fwd_hold >= r_fwd_min);

    // Supply: fail when the sample exceeds the programmed maximum
    assign w_sup_start = smp_valid && (smp_chan == CHAN_SUPPLY);
    assign w_sup_a     = EVAL_W'(smp_data);
    assign w_sup_b     = EVAL_W'(r_supply_max);

    swr_trip_eval u_swr_eval (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_start    (w_swr_start),
        .i_a        (w_swr_a),
        .i_b        (w_swr_b),
        .i_gate     (w_swr_gate),
        .i_enable   (r_enable),
        .i_flush    (w_flush),
        .i_clear    (w_clear),
        .i_trip_cnt (r_trip_cnt),
        .o_trip     (w_swr_trip)
    );

    swr_trip_eval u_sup_eval (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_start    (w_sup_start),
        .i_a        (w_sup_a),
        .i_b        (w_sup_b),
        .i_gate     (1'b1),
        .i_enable   (r_enable),
        .i_flush    (w_flush),
        .i_clear    (w_clear),
        .i_trip_cnt (r_trip_cnt),
        .o_trip     (w_ov_trip)
    );

    // Registered inhibit, one edge behind the trip latches
    always_ff @(posedge aclk) begin
        if (!aresetn) r_tx_inhibit <= 1'b0;
        else          r_tx_inhibit <= w_swr_trip | w_ov_trip;
    end

    assign tx_inhibit = r_tx_inhibit;

endmodule

// File: tb/tb_axi_swr_protect.sv
// Self-checking bench for axi_swr_protect: scenario tasks push expected
// register reads to a queue and compare them as the read data returns.
module tb_axi_swr_protect;

    localparam logic [2:0] R_CTRL = 3'd0, R_RHO = 3'd1, R_FWD_MIN = 3'd2;
    localparam logic [2:0] R_SUP_MAX = 3'd3, R_TRIP_CNT = 3'd4, R_STATUS = 3'd5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        smp_valid = 1'b0;
    logic [2:0]  smp_chan = 3'd0;
    logic [11:0] smp_data = 12'd0;
    logic        tx_inhibit;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rst_vals[8] = '{32'h0, 32'h80, 32'h100, 32'hFFF, 32'h3, 32'h0, 32'h0, 32'h0};

    axi_swr_protect_if #(.ADDR_W(16), .DATA_W(32)) s_axi ();

    axi_swr_protect #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .smp_valid  (smp_valid),
        .smp_chan   (smp_chan),
        .smp_data   (smp_data),
        .tx_inhibit (tx_inhibit),
        .s_axi      (s_axi)
    );

    always #5 aclk = ~aclk;

    // All tasks enter and leave on a falling edge
    task automatic axi_write(input logic [2:0] off, input logic [31:0] data);
        s_axi.awaddr = {11'd0, off, 2'b00};
        s_axi.wdata = data; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        @(negedge aclk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        n_tests++;
        if (s_axi.bvalid !== 1'b1) begin
            n_fail++; $display("FAIL wr_bvalid off=%0d got=%b want=1", off, s_axi.bvalid);
        end
        for (int i = 0; i < 8 && s_axi.bvalid; i++) @(negedge aclk);
    endtask

    task automatic axi_read(input logic [2:0] off, output logic [31:0] data);
        s_axi.araddr = {11'd0, off, 2'b00};
        s_axi.arvalid = 1'b1;
        @(negedge aclk);
        s_axi.arvalid = 1'b0;
        for (int i = 0; i < 8 && !s_axi.rvalid; i++) @(negedge aclk);
        data = s_axi.rvalid ? s_axi.rdata : 32'hDEAD_BEEF;
        @(negedge aclk);
    endtask

    task automatic sample(input logic [2:0] ch, input logic [11:0] d);
        smp_valid = 1'b1; smp_chan = ch; smp_data = d;
        @(negedge aclk);
        smp_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        aresetn = 1'b0;
        settle(3);
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (tx_inhibit !== 1'b0) begin n_fail++; $display("FAIL reset_tx got=%b want=0", tx_inhibit); end
        n_tests++;
        if (s_axi.arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready got=%b want=1", s_axi.arready); end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(rst_vals[i]);
            axi_read(3'(i), d);
            e = exp_q.pop_front(); n_tests++;
            if (d !== e) begin n_fail++; $display("FAIL reset_reg%0d got=%h want=%h", i, d, e); end
        end
    endtask

    task automatic test_swr_trip();
        logic [31:0] d, e;
        axi_write(R_CTRL, 32'h1);
        axi_write(R_RHO, 32'h80);
        sample(3'd0, 12'h400); settle(3);
        // rev*256 = 0x30000 > fwd*RHO = 0x20000: each rev sample fails
        repeat (2) begin sample(3'd1, 12'h300); settle(4); end
        exp_q.push_back(32'h0400_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL swr_after_two got=%h want=%h", d, e); end
        sample(3'd1, 12'h300);
        settle(2);
        n_tests++;
        if (tx_inhibit !== 1'b0) begin n_fail++; $display("FAIL swr_tx_early got=%b want=0", tx_inhibit); end
        settle(1);
        n_tests++;
        if (tx_inhibit !== 1'b1) begin n_fail++; $display("FAIL swr_tx_set got=%b want=1", tx_inhibit); end
        exp_q.push_back(32'h0400_0005);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL swr_status got=%h want=%h", d, e); end
    endtask

    // Clear with enable kept; trip drops on the write edge, inhibit one edge later
    task automatic test_clear();
        logic [31:0] d, e;
        s_axi.awaddr = {11'd0, R_CTRL, 2'b00}; s_axi.wdata = 32'h3; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        @(negedge aclk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        n_tests++;
        if (tx_inhibit !== 1'b1) begin n_fail++; $display("FAIL clear_tx_lag got=%b want=1", tx_inhibit); end
        @(negedge aclk);
        n_tests++;
        if (tx_inhibit !== 1'b0) begin n_fail++; $display("FAIL clear_tx got=%b want=0", tx_inhibit); end
        exp_q.push_back(32'h0400_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL clear_status got=%h want=%h", d, e); end
    endtask

    task automatic test_fwd_min();
        logic [31:0] d, e;
        logic [11:0] pat[5] = '{12'h300, 12'h300, 12'h100, 12'h300, 12'h300};
        sample(3'd0, 12'h0C0); settle(3);
        repeat (5) begin sample(3'd1, 12'hFFF); settle(4); end
        exp_q.push_back(32'h00C0_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL fwd_below_min got=%h want=%h", d, e); end
        sample(3'd0, 12'h400); settle(3);
        for (int i = 0; i < 5; i++) begin sample(3'd1, pat[i]); settle(4); end
        exp_q.push_back(32'h0400_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL fail_pass_fail got=%h want=%h", d, e); end
        sample(3'd1, 12'h300); settle(4);
        exp_q.push_back(32'h0400_0005);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL third_consecutive got=%h want=%h", d, e); end
        axi_write(R_CTRL, 32'h3); settle(2);
        // Boundaries: fwd == FWD_MIN counts; rev*256 == fwd*RHO (0x8000) is a pass
        axi_write(R_TRIP_CNT, 32'h1);
        sample(3'd0, 12'h100); settle(3);
        sample(3'd1, 12'h080); settle(4);
        exp_q.push_back(32'h0100_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL equal_is_pass got=%h want=%h", d, e); end
        sample(3'd1, 12'h081); settle(4);
        exp_q.push_back(32'h0100_0005);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL fwd_eq_min_trip got=%h want=%h", d, e); end
        axi_write(R_CTRL, 32'h3); settle(2);
    endtask

    task automatic test_supply();
        logic [31:0] d, e;
        axi_write(R_SUP_MAX, 32'h900);
        axi_write(R_TRIP_CNT, 32'h0);
        exp_q.push_back(32'h900);
        axi_read(R_SUP_MAX, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL sup_max_rb got=%h want=%h", d, e); end
        exp_q.push_back(32'h0);
        axi_read(R_TRIP_CNT, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL trip_cnt_rb got=%h want=%h", d, e); end
        sample(3'd0, 12'h400); settle(3);
        sample(3'd3, 12'h123); settle(2);
        sample(3'd5, 12'h900); settle(4);
        exp_q.push_back(32'h0400_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL sup_at_max got=%h want=%h", d, e); end
        sample(3'd5, 12'h901); settle(4);
        exp_q.push_back(32'h0400_0006);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL sup_over got=%h want=%h", d, e); end
        axi_write(R_CTRL, 32'h3); settle(2);
    endtask

    task automatic test_clear_collision();
        logic [31:0] d, e;
        axi_write(R_TRIP_CNT, 32'h3);
        axi_write(R_CTRL, 32'h3); settle(2);
        repeat (2) begin sample(3'd1, 12'h300); settle(4); end
        sample(3'd1, 12'h300);
        @(negedge aclk);
        axi_write(R_CTRL, 32'h3);   // accepted on the edge the trip sets
        settle(2);
        exp_q.push_back(32'h0400_0005);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL set_beats_clear got=%h want=%h", d, e); end
    endtask

    task automatic test_disable();
        logic [31:0] d, e;
        axi_write(R_TRIP_CNT, 32'h2);
        sample(3'd1, 12'h300); settle(4);
        axi_write(R_CTRL, 32'h0);
        axi_write(R_CTRL, 32'h1);
        sample(3'd1, 12'h300); settle(4);
        exp_q.push_back(32'h0400_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL dis_cnt_zeroed got=%h want=%h", d, e); end
        sample(3'd1, 12'h300); settle(4);
        axi_write(R_CTRL, 32'h0); settle(2);
        sample(3'd1, 12'h300); settle(4);
        exp_q.push_back(32'h0400_0005);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL dis_retains_trip got=%h want=%h", d, e); end
        axi_write(R_CTRL, 32'h2); settle(3);
        sample(3'd0, 12'h555); settle(2);
        exp_q.push_back(32'h0555_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL dis_fwd_capture got=%h want=%h", d, e); end
        // b = 0x555*0x80 = 0x2AA80 < 0x30000: would trip at count 1 unless flushed
        axi_write(R_TRIP_CNT, 32'h1);
        axi_write(R_CTRL, 32'h1);
        sample(3'd1, 12'h300);
        axi_write(R_CTRL, 32'h0);
        settle(4);
        exp_q.push_back(32'h0555_0000);
        axi_read(R_STATUS, d); e = exp_q.pop_front(); n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL flush got=%h want=%h", d, e); end
    endtask

    task automatic test_reset_midread();
        logic [31:0] d, e;
        axi_write(R_CTRL, 32'h1);
        sample(3'd1, 12'h300); settle(4);
        n_tests++;
        if (tx_inhibit !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tx got=%b want=1", tx_inhibit); end
        s_axi.rready = 1'b0;
        s_axi.araddr = {11'd0, R_STATUS, 2'b00};
        s_axi.arvalid = 1'b1;
        @(negedge aclk);
        s_axi.arvalid = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.arready !== 1'b0) begin
            n_fail++; $display("FAIL rd_stall rvalid=%b arready=%b want 1/0", s_axi.rvalid, s_axi.arready);
        end
        aresetn = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin
            n_fail++; $display("FAIL rst_rd rvalid=%b arready=%b want 0/1", s_axi.rvalid, s_axi.arready);
        end
        n_tests++;
        if (tx_inhibit !== 1'b0) begin n_fail++; $display("FAIL rst_tx got=%b want=0", tx_inhibit); end
        aresetn = 1'b1;
        s_axi.rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(rst_vals[i]);
            axi_read(3'(i), d);
            e = exp_q.pop_front(); n_tests++;
            if (d !== e) begin n_fail++; $display("FAIL rst2_reg%0d got=%h want=%h", i, d, e); end
        end
    endtask

    initial begin
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        s_axi.araddr = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b1;
        @(negedge aclk);
        test_reset();
        test_swr_trip();
        test_clear();
        test_fwd_min();
        test_supply();
        test_clear_collision();
        test_clear();
        test_disable();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
